// File: rtl/aes192_iter_enc_if.sv
// Block-source / ciphertext-sink handshake bundle for the iterative AES-192 engine.
interface aes192_if;
  logic         in_valid;
  logic         in_ready;
  logic         in_new_key;
  logic [191:0] key;
  logic [127:0] plaintext;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] ciphertext;
  logic         busy;

  modport master (
    output in_valid, in_new_key, key, plaintext, out_ready,
    input  in_ready, out_valid, ciphertext, busy
  );

  modport slave (
    input  in_valid, in_new_key, key, plaintext, out_ready,
    output in_ready, out_valid, ciphertext, busy
  );
endinterface

// File: rtl/aes192_iter_enc.sv
// Iterative AES-192 encryptor: one shared round datapath and one key-expansion step,
// sequenced by a small FSM with an optional cached 52-word key schedule.
module aes192_iter_enc #(
  parameter bit KEY_CACHE = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  aes192_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND, DONE} fsm_t;

  fsm_t         fsm_r;
  logic [3:0]   cnt_r;
  logic         sched_valid_r;
  logic [127:0] st_r;
  logic         in_ready_r;
  logic         out_valid_r;
  logic         busy_r;
  logic [31:0]  w_r [0:51];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      p  = p ^ (aa & {8{b[i]}});
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254) followed by the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] y;
    logic [7:0] inv;
    y   = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      y   = gmul(y, y);
      inv = gmul(inv, y);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  logic [7:0]   sr_s [0:3][0:3];
  logic [127:0] full_s;
  logic [127:0] fin_s;
  logic [127:0] rk_s;
  logic [127:0] round_s;

  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign sr_s[r][c] = sbox(st_r[127-8*(4*((c+r)%4)+r) -: 8]);
      assign fin_s[127-8*(4*c+r) -: 8] = sr_s[r][c];
    end
    assign full_s[127-32*c -: 32] = {
      xtime(sr_s[0][c]) ^ xtime(sr_s[1][c]) ^ sr_s[1][c] ^ sr_s[2][c] ^ sr_s[3][c],
      sr_s[0][c] ^ xtime(sr_s[1][c]) ^ xtime(sr_s[2][c]) ^ sr_s[2][c] ^ sr_s[3][c],
      sr_s[0][c] ^ sr_s[1][c] ^ xtime(sr_s[2][c]) ^ xtime(sr_s[3][c]) ^ sr_s[3][c],
      xtime(sr_s[0][c]) ^ sr_s[0][c] ^ sr_s[1][c] ^ sr_s[2][c] ^ xtime(sr_s[3][c])
    };
  end

  assign rk_s = {w_r[{cnt_r, 2'b00}], w_r[{cnt_r, 2'b01}],
                 w_r[{cnt_r, 2'b10}], w_r[{cnt_r, 2'b11}]};

  // Select round flavour: key whitening, full round, or final round without MixColumns
  always_comb begin
    round_s = 128'h0;
    if (cnt_r == 4'd0) begin
      round_s = st_r ^ rk_s;
    end else if (cnt_r == 4'd12) begin
      round_s = fin_s ^ rk_s;
    end else begin
      round_s = full_s ^ rk_s;
    end
  end

  // Key expansion step k = cnt+1 derives six words from the previous six
  logic [2:0]  ksel_s;
  logic [5:0]  kb_s;
  logic [7:0]  rcon_s;
  logic [31:0] p_s  [0:5];
  logic [31:0] nw_s [0:5];
  logic [31:0] t_s;

  assign ksel_s = cnt_r[2:0];
  assign kb_s   = 6'({ksel_s, 2'b00}) + 6'({ksel_s, 1'b0});
  assign rcon_s = 8'h01 << ksel_s;

  for (genvar j = 0; j < 6; j++) begin : g_prev
    assign p_s[j] = w_r[kb_s + 6'(j)];
  end

  assign t_s = {sbox(p_s[5][23:16]), sbox(p_s[5][15:8]), sbox(p_s[5][7:0]),
                sbox(p_s[5][31:24])} ^ {rcon_s, 24'h000000};
  assign nw_s[0] = p_s[0] ^ t_s;
  for (genvar j = 1; j < 6; j++) begin : g_next
    assign nw_s[j] = p_s[j] ^ nw_s[j-1];
  end

  logic hs_s;
  logic exp_s;
  assign hs_s  = rst_n && (fsm_r == IDLE) && bus.in_valid;
  assign exp_s = rst_n && (fsm_r == KEYEXP);

  // Schedule storage: key words on the handshake, expanded words during KEYEXP; w52/w53 never stored
  always_ff @(posedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (hs_s) w_r[i] <= bus.key[191-32*i -: 32];
    end
    for (int i = 6; i < 52; i++) begin
      if (exp_s && (ksel_s == 3'(i/6 - 1))) w_r[i] <= nw_s[i%6];
    end
  end

  // Controller FSM with registered handshake/status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_r         <= IDLE;
      cnt_r         <= 4'd0;
      sched_valid_r <= 1'b0;
      st_r          <= 128'h0;
      in_ready_r    <= 1'b1;
      out_valid_r   <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      case (fsm_r)
        IDLE: begin
          if (bus.in_valid) begin
            st_r       <= bus.plaintext;
            cnt_r      <= 4'd0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            if (bus.in_new_key || !sched_valid_r || (KEY_CACHE == 1'b0)) begin
              fsm_r <= KEYEXP;
            end else begin
              fsm_r <= ROUND;
            end
          end
        end
        KEYEXP: begin
          if (cnt_r == 4'd7) begin
            fsm_r         <= ROUND;
            cnt_r         <= 4'd0;
            sched_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        ROUND: begin
          st_r <= round_s;
          if (cnt_r == 4'd12) begin
            fsm_r       <= DONE;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            fsm_r       <= IDLE;
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
          end
        end
        default: begin
          fsm_r       <= IDLE;
          cnt_r       <= 4'd0;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.busy       = busy_r;
  assign bus.ciphertext = st_r;

endmodule

// File: tb/tb_aes192_iter_enc.sv
// Directed bench for aes192_iter_enc: FIPS-197 C.2 and all-zero vectors, latency,
// key caching, backpressure, mid-operation reset and a non-caching instance.
module tb_aes192_iter_enc;

  localparam logic [191:0] KEY_C2  = 192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [127:0] PT_C2   = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C2   = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT_ZERO = 128'haae06992acbf52a3e8f4a96ec9300bd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_new_key = 1'b0;
  logic         out_ready = 1'b1;
  logic [191:0] key = 192'h0;
  logic [127:0] pt = 128'h0;

  aes192_if bus ();
  aes192_if bus_nc ();

  assign bus.in_valid      = in_valid & ~sel;
  assign bus.in_new_key    = in_new_key;
  assign bus.key           = key;
  assign bus.plaintext     = pt;
  assign bus.out_ready     = out_ready;
  assign bus_nc.in_valid   = in_valid & sel;
  assign bus_nc.in_new_key = in_new_key;
  assign bus_nc.key        = key;
  assign bus_nc.plaintext  = pt;
  assign bus_nc.out_ready  = out_ready;

  logic         in_ready_m;
  logic         out_valid_m;
  logic         busy_m;
  logic [127:0] ct_m;
  assign in_ready_m  = sel ? bus_nc.in_ready   : bus.in_ready;
  assign out_valid_m = sel ? bus_nc.out_valid  : bus.out_valid;
  assign busy_m      = sel ? bus_nc.busy       : bus.busy;
  assign ct_m        = sel ? bus_nc.ciphertext : bus.ciphertext;

  aes192_iter_enc #(.KEY_CACHE(1'b1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  aes192_iter_enc #(.KEY_CACHE(1'b0)) dut_nc (.clk(clk), .rst_n(rst_n), .bus(bus_nc));

  int checks = 0;
  int fails  = 0;
  int lat;
  int bcnt;

  // Called at a negedge; returns at the negedge following the input handshake edge.
  task automatic start(input logic [191:0] k, input logic [127:0] p, input logic nk);
    key = k;
    pt = p;
    in_new_key = nk;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_new_key = 1'b0;
  endtask

  task automatic wait_done(output int l, output int b);
    l = 0;
    b = 0;
    while (out_valid_m !== 1'b1 && l < 60) begin
      if (busy_m === 1'b1) b++;
      @(negedge clk);
      l++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid_m); end
    checks++; if (busy_m !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b expected 0", busy_m); end
    checks++; if (ct_m !== 128'h0) begin fails++; $display("FAIL reset_ciphertext: got %h expected 0", ct_m); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_c2;
    out_ready = 1'b1;
    start(KEY_C2, PT_C2, 1'b1);
    wait_done(lat, bcnt);
    checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL c2_ct: got %h expected %h", ct_m, CT_C2); end
    checks++; if (lat != 21) begin fails++; $display("FAIL c2_latency: got %0d expected 21", lat); end
    checks++; if (bcnt != 21) begin fails++; $display("FAIL c2_busy_cycles: got %0d expected 21", bcnt); end
    @(negedge clk);
    checks++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL c2_idle_in_ready: got %0b expected 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL c2_idle_out_valid: got %0b expected 0", out_valid_m); end
  endtask

  task automatic test_cached_key;
    start(KEY_C2, PT_C2, 1'b0);
    wait_done(lat, bcnt);
    checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL cached_ct: got %h expected %h", ct_m, CT_C2); end
    checks++; if (lat != 13) begin fails++; $display("FAIL cached_latency: got %0d expected 13", lat); end
    checks++; if (bcnt != 13) begin fails++; $display("FAIL cached_busy_cycles: got %0d expected 13", bcnt); end
    @(negedge clk);
    start(192'h0, 128'h0, 1'b1);
    wait_done(lat, bcnt);
    checks++; if (ct_m !== CT_ZERO) begin fails++; $display("FAIL zero_ct: got %h expected %h", ct_m, CT_ZERO); end
    checks++; if (lat != 21) begin fails++; $display("FAIL zero_latency: got %0d expected 21", lat); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    start(KEY_C2, PT_C2, 1'b1);
    wait_done(lat, bcnt);
    checks++; if (lat != 21) begin fails++; $display("FAIL bp_latency: got %0d expected 21", lat); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) begin
        pt = 128'hffeeddccbbaa99887766554433221100;
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      checks++; if (out_valid_m !== 1'b1) begin fails++; $display("FAIL bp_out_valid[%0d]: got %0b expected 1", i, out_valid_m); end
      checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL bp_ct[%0d]: got %h expected %h", i, ct_m, CT_C2); end
      checks++; if (in_ready_m !== 1'b0) begin fails++; $display("FAIL bp_in_ready[%0d]: got %0b expected 0", i, in_ready_m); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (in_ready_m !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready: got %0b expected 1", in_ready_m); end
    checks++; if (out_valid_m !== 1'b0) begin fails++; $display("FAIL bp_release_out_valid: got %0b expected 0", out_valid_m); end
    checks++; if (busy_m !== 1'b0) begin fails++; $display("FAIL bp_release_busy: got %0b expected 0", busy_m); end
  endtask

  task automatic test_reset_mid;
    start(KEY_C2, PT_C2, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 || ct_m !== 128'h0) begin
      fails++; $display("FAIL rst_keyexp_outputs: got rdy=%0b vld=%0b busy=%0b ct=%h expected 1/0/0/0", in_ready_m, out_valid_m, busy_m, ct_m);
    end
    rst_n = 1'b1;
    start(KEY_C2, PT_C2, 1'b0);
    wait_done(lat, bcnt);
    checks++; if (lat != 21) begin fails++; $display("FAIL rst_keyexp_relatency: got %0d expected 21", lat); end
    checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL rst_keyexp_ct: got %h expected %h", ct_m, CT_C2); end
    @(negedge clk);
    start(KEY_C2, PT_C2, 1'b0);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (in_ready_m !== 1'b1 || out_valid_m !== 1'b0 || busy_m !== 1'b0 || ct_m !== 128'h0) begin
      fails++; $display("FAIL rst_round_outputs: got rdy=%0b vld=%0b busy=%0b ct=%h expected 1/0/0/0", in_ready_m, out_valid_m, busy_m, ct_m);
    end
    rst_n = 1'b1;
    start(KEY_C2, PT_C2, 1'b0);
    wait_done(lat, bcnt);
    checks++; if (lat != 21) begin fails++; $display("FAIL rst_round_relatency: got %0d expected 21", lat); end
    checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL rst_round_ct: got %h expected %h", ct_m, CT_C2); end
    @(negedge clk);
  endtask

  task automatic test_ignore_busy;
    start(KEY_C2, PT_C2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      in_new_key = ~in_new_key;
      key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      pt = {$urandom, $urandom, $urandom, $urandom};
    end
    in_valid = 1'b0;
    in_new_key = 1'b0;
    wait_done(lat, bcnt);
    checks++; if (lat + 6 != 13) begin fails++; $display("FAIL ignore_latency: got %0d expected 13", lat + 6); end
    checks++; if (bcnt + 6 != 13) begin fails++; $display("FAIL ignore_busy_cycles: got %0d expected 13", bcnt + 6); end
    checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL ignore_ct: got %h expected %h", ct_m, CT_C2); end
    @(negedge clk);
  endtask

  task automatic test_no_cache;
    sel = 1'b1;
    for (int n = 0; n < 2; n++) begin
      start(KEY_C2, PT_C2, 1'b0);
      wait_done(lat, bcnt);
      checks++; if (lat != 21) begin fails++; $display("FAIL nocache_latency[%0d]: got %0d expected 21", n, lat); end
      checks++; if (ct_m !== CT_C2) begin fails++; $display("FAIL nocache_ct[%0d]: got %h expected %h", n, ct_m, CT_C2); end
      @(negedge clk);
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset;
    test_fips_c2;
    test_cached_key;
    test_backpressure;
    test_reset_mid;
    test_ignore_busy;
    test_no_cache;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
